seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 149 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with double-buffered patterns, PWM dimming
// and optional digit blinking (compile with SEG_BLINK_EN to build the blinker).
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   enable_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [7:0]              seg_data,
    output logic                    frame_done,
    output logic                    load_pending
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(SCAN_DIV - 2);
    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [3:0]              pwm;
    logic [8*NUM_DIGITS-1:0] active;
    logic [8*NUM_DIGITS-1:0] shadow;
    logic                    tick;
    logic                    wrap;
    logic                    pwm_on;
    logic                    blink_off;
    logic                    blank;
    logic                    en_sel;
    logic                    bl_sel;
    logic [7:0]              cur_byte;
    logic [NUM_DIGITS-1:0]   onehot;

    assign tick   = (cnt == CNT_MAX);
    assign wrap   = tick && (idx == '0);
    assign pwm_on = (pwm <= brightness);
    assign blank  = ~en_sel | ~pwm_on | blink_off;

    // Select the byte, one-hot code and mask bits of the digit being scanned
    always_comb begin
        cur_byte = '0;
        onehot   = '0;
        en_sel   = 1'b0;
        bl_sel   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_byte  = active[k*8 +: 8];
                onehot[k] = 1'b1;
                en_sel    = enable_mask[k];
                bl_sel    = blink_mask[k];
            end
        end
    end

    // Prescaler and scan index; index walks downward and wraps per frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= IDX_TOP;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Free-running PWM phase counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 1'b1;
        end
    end

    // Registered display outputs; frame_done is timed to the wrapping tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit      <= '0;
            seg_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            digit      <= blank ? '0 : onehot;
            seg_data   <= blank ? 8'h00 : cur_byte;
            frame_done <= (cnt == CNT_PRE) && (idx == '0);
        end
    end

    // Shadow capture and frame-aligned transfer to the active buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow       <= '0;
            active       <= '0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= seg_in;
            end
            if (wrap && load_pending) begin
                active <= shadow;
            end
            if (load) begin
                load_pending <= 1'b1;
            end else if (wrap) begin
                load_pending <= 1'b0;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          phase;

    assign blink_off = bl_sel & ~phase;

    // Blink phase flips after every BLINK_FRAMES completed frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (wrap) begin
            if (fcnt == FR_MAX) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink;

    assign unused_blink = bl_sel;
    assign blink_off    = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: 4 digits, 4-cycle slots, 2-frame blink.
// Cycle model feeds a scoreboard; table segments plus directed corner cases.
module tb_seg_scan_mux;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int BF = 2;
`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] seg_in = '0;
    logic        load = 1'b0;
    logic [3:0]  enable_mask = 4'hF;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  digit;
    logic [7:0]  seg_data;
    logic        frame_done;
    logic        load_pending;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (D),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .load        (load),
        .enable_mask (enable_mask),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .digit       (digit),
        .seg_data    (seg_data),
        .frame_done  (frame_done),
        .load_pending(load_pending)
    );

    typedef struct {
        logic [3:0] d;
        logic [7:0] s;
        logic       f;
        logic       p;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [31:0] si;
        logic [3:0]  en;
        logic [3:0]  bm;
        logic [3:0]  br;
        int          n;
        int          on;
    } vec_t;

    exp_t sb[$];
    vec_t vt[7];

    int checks = 0;
    int errors = 0;
    int stepn = 0;
    int last_fd = -1;

    int          m_cnt, m_idx, m_pwm, m_fcnt;
    bit          m_pend, m_phase;
    logic [31:0] m_act, m_shd;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_idx   = N - 1;
        m_pwm   = 0;
        m_fcnt  = 0;
        m_pend  = 1'b0;
        m_phase = 1'b1;
        m_act   = '0;
        m_shd   = '0;
        last_fd = -1;
        sb.delete();
    endtask

    task automatic step(input logic ld, input logic [31:0] si);
        exp_t e;
        bit   tk, wr, off;
        @(negedge clk);
        load   = ld;
        seg_in = si;
        tk  = (m_cnt == D - 1);
        wr  = tk && (m_idx == 0);
        off = !enable_mask[m_idx] || (m_pwm > int'(brightness)) ||
              (BLINK && blink_mask[m_idx] && !m_phase);
        e.d = off ? 4'h0 : 4'(1 << m_idx);
        e.s = off ? 8'h00 : m_act[m_idx*8 +: 8];
        e.f = (m_cnt == D - 2) && (m_idx == 0);
        e.p = ld ? 1'b1 : (wr ? 1'b0 : m_pend);
        sb.push_back(e);
        if (wr && m_pend) m_act = m_shd;
        if (ld) m_shd = si;
        m_pend = e.p;
        if (wr) begin
            m_fcnt++;
            if (m_fcnt == BF) begin
                m_fcnt  = 0;
                m_phase = !m_phase;
            end
        end
        if (tk) begin
            m_cnt = 0;
            m_idx = (m_idx == 0) ? N - 1 : m_idx - 1;
        end else begin
            m_cnt++;
        end
        m_pwm = (m_pwm + 1) % 16;
        @(posedge clk);
        #1;
        stepn++;
        e = sb.pop_front();
        check("digit", digit, e.d);
        check("seg_data", seg_data, e.s);
        check("frame_done", frame_done, e.f);
        check("load_pending", load_pending, e.p);
        if (frame_done) begin
            if (last_fd >= 0) check("fd_period", stepn - last_fd, 16);
            last_fd = stepn;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, digit, 4'h0);
        check({tag, "_seg"}, seg_data, 8'h00);
        check({tag, "_fd"}, frame_done, 1'b0);
        check({tag, "_pend"}, load_pending, 1'b0);
    endtask

    initial begin
        logic [7:0] want[4];
        int         on_cnt;
        bit         done;
        want = '{8'h11, 8'h22, 8'h33, 8'h44};

        vt[0] = '{1'b1, 32'hAABBCCDD, 4'hF, 4'h0, 4'hF, 3, -1};
        vt[1] = '{1'b1, 32'h55667788, 4'hF, 4'h0, 4'hF, 32, 32};
        vt[2] = '{1'b0, 32'h0, 4'hF, 4'h0, 4'h3, 32, 8};
        vt[3] = '{1'b0, 32'h0, 4'hB, 4'h0, 4'hF, 32, 24};
        vt[4] = '{1'b0, 32'h0, 4'hB, 4'h0, 4'h3, 32, -1};
        vt[5] = '{1'b0, 32'h0, 4'hF, 4'h0, 4'h0, 32, 2};
        vt[6] = '{1'b0, 32'h0, 4'hF, 4'h1, 4'hF, 64, BLINK ? 56 : 64};

        model_reset();
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0);
            check("scan_seq", digit, 4'b1000 >> (i / 4));
            if (i == 14) check("first_fd", frame_done, 1'b1);
        end

        for (int i = 0; i < 5; i++) step(1'b0, '0);
        step(1'b1, 32'h11223344);
        check("pend_set", load_pending, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, '0);
            if (load_pending == 1'b0) done = 1'b1;
            else check("old_data_held", seg_data, 8'h00);
        end
        check("pend_clear_timeout", done, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            step(1'b0, '0);
            if ((j % 4) == 1) check("new_frame_byte", seg_data, want[j / 4]);
        end

        for (int v = 0; v < 7; v++) begin
            enable_mask = vt[v].en;
            blink_mask  = vt[v].bm;
            brightness  = vt[v].br;
            on_cnt = 0;
            for (int c = 0; c < vt[v].n; c++) begin
                step((c == 0) ? vt[v].ld : 1'b0, (c == 0) ? vt[v].si : '0);
                if (digit != 4'h0) on_cnt++;
            end
            if (vt[v].on >= 0) check($sformatf("on_count_%0d", v), on_cnt, vt[v].on);
        end

        enable_mask = 4'hF;
        blink_mask  = 4'h0;
        brightness  = 4'hF;
        for (int i = 0; i < 20 && !(m_cnt == D - 1 && m_idx == 0); i++) step(1'b0, '0);
        check("fd_at_load", frame_done, 1'b1);
        step(1'b1, 32'hDEADBEEF);
        check("pend_after_fd_load", load_pending, 1'b1);
        for (int j = 1; j <= 17; j++) begin
            step(1'b0, '0);
            if (j == 15) check("pend_held_frame", load_pending, 1'b1);
            if (j == 16) check("pend_cleared", load_pending, 1'b0);
            if (j == 17) check("deferred_byte", seg_data, 8'hDE);
        end

        step(1'b1, 32'h12345678);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        check("pend_before_rst", load_pending, 1'b1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0);
            if (i == 0) check("restart_digit", digit, 4'b1000);
            check("restart_blank", seg_data, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
